core_host_driver: RTL and testbench
===================================

// Module: core_host_driver
// PURPOSE
//  Synthesizable host for the core's op/in/out handshake protocol; drives the core's
//  op and input ports and checks its output port. Replays an op-mode ROM, streams an
//  input-data ROM into the core on every op_mode==0 (load), and compares each output
//  against a golden ROM. Used on FPGA/emulation builds in place of the simulation bench.
// PARAMETERS
//  OP_NUM     41        number of op modes issued per run
//  IN_LEN     2048      bytes streamed per load op (op_mode==0)
//  GOLDEN_NUM 1984      expected output samples per run
//  OUT_W      14        output data width (signed)
//  ERR_W      16        error counter width
//  MAX_CYCLE  10000000  watchdog limit, in cycles after start
// PORTS
//  i_clk          in   1      clock
//  i_rst          in   1      asynchronous active-high reset
//  i_start        in   1      start pulse; honoured in IDLE and DONE only
//  o_op_addr      out  10     op ROM address (= op index)
//  i_op_rom       in   4      op ROM data, combinational read
//  o_in_addr      out  11     input ROM address (= byte index)
//  i_in_rom       in   8      input ROM data, combinational read
//  o_gold_addr    out  12     golden ROM address (= output index)
//  i_gold_rom     in   OUT_W  golden ROM data, combinational read
//  i_op_ready     in   1      core ready for an op
//  o_op_valid     out  1      op strobe, one cycle
//  o_op_mode      out  4      op mode; 0 when o_op_valid low
//  o_in_valid     out  1      input byte valid
//  o_in_data      out  8      input byte
//  i_in_ready     in   1      core accepts byte
//  i_out_valid    in   1      core output valid
//  i_out_data     in   OUT_W  core output, signed
//  o_done         out  1      run finished (sticky until start/reset)
//  o_err_cnt      out  ERR_W  mismatch count, saturating at all-ones
//  o_overflow     out  1      sticky: output seen after GOLDEN_NUM
//  o_timeout      out  1      sticky: watchdog expired
// BEHAVIOUR
//  Reset: all outputs and counters 0, FSM IDLE; reset mid-run aborts cleanly.
//  All core-facing outputs registered.
//  FSM: IDLE -start-> WAIT_RDY; WAIT_RDY -i_op_ready sampled 1-> GAP; GAP -> ISSUE
//   (always exactly one idle cycle); ISSUE: o_op_valid=1, o_op_mode=i_op_rom for
//   exactly one cycle, op_idx++; then LOAD if mode==0, else WAIT_RDY, or DRAIN
//   when op_idx reaches OP_NUM.
//  LOAD: o_in_valid held 1; o_in_data=ROM[in_idx] held stable while i_in_ready=0;
//   transfer on edge with o_in_valid&&i_in_ready, in_idx++. After the IN_LEN-th
//   transfer o_in_valid drops next cycle, in_idx resets to 0, go to WAIT_RDY or DRAIN.
//  DRAIN: wait until gold_idx==GOLDEN_NUM -> DONE, o_done=1.
//  Checker runs in every non-IDLE state: on i_out_valid with gold_idx<GOLDEN_NUM,
//   compare i_out_data vs i_gold_rom (full OUT_W bits); mismatch -> err_cnt++;
//   gold_idx++. i_out_valid at gold_idx==GOLDEN_NUM -> o_overflow=1; err unchanged.
//  Watchdog: cycle counter from start; at MAX_CYCLE -> o_timeout=1, FSM DONE,
//   o_done=1, all valids low.
//  i_start in DONE: clears counters/flags, restarts at op_idx 0. Ignored mid-run.
//  i_op_ready changes during GAP/ISSUE/LOAD are ignored.
// STRUCTURE
//  Shared package core_host_pkg: FSM state enum (IDLE,WAIT_RDY,GAP,ISSUE,LOAD,
//   DRAIN,DONE), OP_LOAD=4'd0, widths OP_W=4, IN_W=8.
//  One sub-module: core_out_checker (gold_idx, compare, err_cnt, overflow).
// TESTING
//  OP_NUM=2, ROM {1,2}, op_ready high -> o_op_valid pulses 2 cycles after sampled
//   ready, modes 1 then 2, o_op_mode=0 otherwise.
//  ROM {0}, IN_LEN=2048, i_in_ready toggling 1,0 -> 2048 transfers matching
//   ROM[0..2047] in order, o_in_valid never drops, data stable on stalls.
//  GOLDEN_NUM=4, outputs equal golden {5,-3,8191,-8192} -> o_done=1, o_err_cnt=0.
//  Same, outputs {5,-2,8191,0} -> o_err_cnt=2, o_done=1.
//  i_rst high mid-LOAD at in_idx=100 -> all outputs 0 same cycle; restart streams
//   from ROM[0].
//  Fifth i_out_valid after GOLDEN_NUM=4 -> o_overflow=1, o_err_cnt unchanged;
//   MAX_CYCLE=50 with op_ready stuck 0 -> o_timeout=1, o_done=1 at cycle 50.

Source files
------------

// File: rtl/core_host_pkg.sv
// Shared types and widths for the core host driver and its output checker.
package core_host_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_RDY, GAP, ISSUE, LOAD, DRAIN, DONE} state_t;

    localparam int OP_W = 4;
    localparam int IN_W = 8;
    localparam logic [OP_W-1:0] OP_LOAD = 4'd0;
endpackage

// File: rtl/core_host_if.sv
// Op / input / output handshake between the host driver (master) and the core (slave).
interface core_host_if #(
    parameter int OUT_W = 14
);
    logic                               o_op_valid;
    logic [core_host_pkg::OP_W-1:0]     o_op_mode;
    logic                               i_op_ready;
    logic                               o_in_valid;
    logic [core_host_pkg::IN_W-1:0]     o_in_data;
    logic                               i_in_ready;
    logic                               i_out_valid;
    logic signed [OUT_W-1:0]            i_out_data;

    modport master (
        output o_op_valid, o_op_mode, o_in_valid, o_in_data,
        input  i_op_ready, i_in_ready, i_out_valid, i_out_data
    );
    modport slave (
        input  o_op_valid, o_op_mode, o_in_valid, o_in_data,
        output i_op_ready, i_in_ready, i_out_valid, i_out_data
    );
endinterface

// File: rtl/core_out_checker.sv
// Compares each core output sample against the golden ROM and counts mismatches.
module core_out_checker #(
    parameter int GOLDEN_NUM = 1984,
    parameter int OUT_W      = 14,
    parameter int ERR_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    active,
    input  logic                    clear,
    input  logic                    out_valid,
    input  logic signed [OUT_W-1:0] out_data,
    input  logic signed [OUT_W-1:0] gold,
    output logic [11:0]             gold_idx,
    output logic [ERR_W-1:0]        err_cnt,
    output logic                    overflow,
    output logic                    complete
);
    localparam logic [11:0] GOLD_END = 12'(GOLDEN_NUM);

    assign complete = (gold_idx == GOLD_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gold_idx <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            gold_idx <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else if (active && out_valid) begin
            if (!complete) begin
                gold_idx <= gold_idx + 12'd1;
                // error count saturates rather than wrapping back to a clean-looking value
                if (out_data != gold && err_cnt != '1)
                    err_cnt <= err_cnt + ERR_W'(1);
            end else begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/core_host_driver.sv
// Replays the op ROM into the core, streams input bytes on load ops and checks outputs.
module core_host_driver
    import core_host_pkg::*;
#(
    parameter int OP_NUM     = 41,
    parameter int IN_LEN     = 2048,
    parameter int GOLDEN_NUM = 1984,
    parameter int OUT_W      = 14,
    parameter int ERR_W      = 16,
    parameter int MAX_CYCLE  = 10000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic [9:0]              o_op_addr,
    input  logic [OP_W-1:0]         i_op_rom,
    output logic [10:0]             o_in_addr,
    input  logic [IN_W-1:0]         i_in_rom,
    output logic [11:0]             o_gold_addr,
    input  logic signed [OUT_W-1:0] i_gold_rom,
    core_host_if.master             core,
    output logic                    o_done,
    output logic [ERR_W-1:0]        o_err_cnt,
    output logic                    o_overflow,
    output logic                    o_timeout
);
    localparam int              CYC_W    = $clog2(MAX_CYCLE + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLE - 1);
    localparam logic [9:0]      OP_LAST  = 10'(OP_NUM - 1);
    localparam logic [9:0]      OP_END   = 10'(OP_NUM);
    localparam logic [10:0]     IN_LAST  = 11'(IN_LEN - 1);

    state_t             state, nxt;
    logic [9:0]         op_idx;
    logic [10:0]        in_idx, in_nxt;
    logic [CYC_W-1:0]   cyc;
    logic               active, restart, timeout_hit, xfer, last_byte, gold_complete;
    logic               op_valid_d, in_valid_d, done_d;
    logic [OP_W-1:0]    op_mode_d;
    logic [IN_W-1:0]    in_data_d;

    assign active      = (state != IDLE) && (state != DONE);
    assign restart     = i_start && (state == IDLE || state == DONE);
    assign timeout_hit = active && (cyc == CYC_LAST);
    assign xfer        = (state == LOAD) && core.o_in_valid && core.i_in_ready;
    assign last_byte   = xfer && (in_idx == IN_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DONE: if (i_start) nxt = WAIT_RDY;
            WAIT_RDY:   if (core.i_op_ready) nxt = GAP;
            GAP:        nxt = ISSUE;
            ISSUE: begin
                if (core.o_op_mode == OP_LOAD) nxt = LOAD;
                else if (op_idx == OP_LAST)    nxt = DRAIN;
                else                           nxt = WAIT_RDY;
            end
            LOAD:       if (last_byte) nxt = (op_idx == OP_END) ? DRAIN : WAIT_RDY;
            DRAIN:      if (gold_complete) nxt = DONE;
            default:    nxt = IDLE;
        endcase
        if (timeout_hit) nxt = DONE;
    end

    // Core-facing outputs are flops loaded from the next state, so each strobe lines up
    // with the state it belongs to and nothing reaches the core combinationally.
    always_comb begin
        op_valid_d = (nxt == ISSUE);
        op_mode_d  = op_valid_d ? i_op_rom : '0;
        in_valid_d = (nxt == LOAD);
        in_data_d  = in_valid_d ? i_in_rom : '0;
        done_d     = (nxt == DONE);
    end

    // The input ROM is addressed with the post-edge index so the registered byte
    // is already the right one on the cycle after each transfer.
    always_comb begin
        in_nxt = in_idx;
        if (restart || last_byte) in_nxt = '0;
        else if (xfer)            in_nxt = in_idx + 11'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            core.o_op_valid <= 1'b0;
            core.o_op_mode  <= '0;
            core.o_in_valid <= 1'b0;
            core.o_in_data  <= '0;
            o_done          <= 1'b0;
            o_timeout       <= 1'b0;
            op_idx          <= '0;
            in_idx          <= '0;
            cyc             <= '0;
        end else begin
            core.o_op_valid <= op_valid_d;
            core.o_op_mode  <= op_mode_d;
            core.o_in_valid <= in_valid_d;
            core.o_in_data  <= in_data_d;
            o_done          <= done_d;
            in_idx          <= in_nxt;
            if (restart) begin
                op_idx    <= '0;
                cyc       <= '0;
                o_timeout <= 1'b0;
            end else begin
                if (state == ISSUE) op_idx <= op_idx + 10'd1;
                if (active)         cyc <= cyc + CYC_W'(1);
                if (timeout_hit)    o_timeout <= 1'b1;
            end
        end
    end

    assign o_op_addr = op_idx;
    assign o_in_addr = in_nxt;

    core_out_checker #(
        .GOLDEN_NUM (GOLDEN_NUM),
        .OUT_W      (OUT_W),
        .ERR_W      (ERR_W)
    ) u_checker (
        .clk        (i_clk),
        .rst        (i_rst),
        .active     (state != IDLE),
        .clear      (restart),
        .out_valid  (core.i_out_valid),
        .out_data   (core.i_out_data),
        .gold       (i_gold_rom),
        .gold_idx   (o_gold_addr),
        .err_cnt    (o_err_cnt),
        .overflow   (o_overflow),
        .complete   (gold_complete)
    );
endmodule

// File: tb/tb_core_host_driver.sv
// Directed bench: scoreboarded op/byte streams, golden compare, reset abort and watchdog.
module tb_core_host_driver;
    logic clk = 1'b0;
    logic rst, start, wd_start;
    always #5 clk = ~clk;

    logic [9:0]         op_addr, wd_op_addr;
    logic [10:0]        in_addr, wd_in_addr;
    logic [11:0]        gold_addr, wd_gold_addr;
    logic               done, overflow, timeout, wd_done, wd_overflow, wd_timeout;
    logic [15:0]        err_cnt, wd_err_cnt;
    logic [3:0]         op_mem [0:1];
    logic [7:0]         in_mem [0:2047];
    logic signed [13:0] gold_mem [0:3];
    logic signed [13:0] bad_vals [0:3];
    logic [3:0]         op_rom;
    logic [7:0]         in_rom;
    logic signed [13:0] gold_rom;

    assign op_rom   = op_mem[op_addr[0]];
    assign in_rom   = in_mem[in_addr];
    assign gold_rom = gold_mem[gold_addr[1:0]];

    core_host_if #(.OUT_W(14)) cif ();
    core_host_if #(.OUT_W(14)) wif ();
    assign wif.i_op_ready  = 1'b0;
    assign wif.i_in_ready  = 1'b0;
    assign wif.i_out_valid = 1'b0;
    assign wif.i_out_data  = '0;

    core_host_driver #(.OP_NUM(2), .IN_LEN(2048), .GOLDEN_NUM(4), .OUT_W(14), .ERR_W(16),
                       .MAX_CYCLE(20000)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_op_addr(op_addr), .i_op_rom(op_rom),
        .o_in_addr(in_addr), .i_in_rom(in_rom),
        .o_gold_addr(gold_addr), .i_gold_rom(gold_rom),
        .core(cif),
        .o_done(done), .o_err_cnt(err_cnt), .o_overflow(overflow), .o_timeout(timeout)
    );

    core_host_driver #(.OP_NUM(2), .IN_LEN(2048), .GOLDEN_NUM(4), .OUT_W(14), .ERR_W(16),
                       .MAX_CYCLE(50)) dut_wd (
        .i_clk(clk), .i_rst(rst), .i_start(wd_start),
        .o_op_addr(wd_op_addr), .i_op_rom(4'd1),
        .o_in_addr(wd_in_addr), .i_in_rom(8'd0),
        .o_gold_addr(wd_gold_addr), .i_gold_rom(14'sd0),
        .core(wif),
        .o_done(wd_done), .o_err_cnt(wd_err_cnt), .o_overflow(wd_overflow), .o_timeout(wd_timeout)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard queues and monitor state
    logic [3:0] op_q[$];
    logic [7:0] byte_q[$];
    int         n_xfer = 0;
    int         load_cnt = 0;
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;

    always @(negedge clk) begin
        logic [4:0] exp_mode;
        logic [8:0] exp_byte;
        if (rst) begin
            pv = 1'b0; pr = 1'b0; load_cnt = 0;
        end else begin
            if (cif.o_op_valid) begin
                exp_mode = (op_q.size() != 0) ? {1'b0, op_q.pop_front()} : 5'h1F;
                check("op_mode", {1'b0, cif.o_op_mode}, exp_mode);
            end else begin
                check("op_mode_idle", cif.o_op_mode, 0);
            end
            if (pv && !pr) begin
                check("in_hold_valid", cif.o_in_valid, 1);
                check("in_hold_data", cif.o_in_data, pd);
            end
            if (pv && !cif.o_in_valid) check("in_len", load_cnt, 2048);
            if (!pv && cif.o_in_valid) load_cnt = 0;
            if (cif.o_in_valid && cif.i_in_ready) begin
                exp_byte = (byte_q.size() != 0) ? {1'b0, byte_q.pop_front()} : 9'h1FF;
                check("in_data", {1'b0, cif.o_in_data}, exp_byte);
                n_xfer++;
                load_cnt++;
            end
            pv = cif.o_in_valid; pr = cif.i_in_ready; pd = cif.o_in_data;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_out(input logic signed [13:0] v);
        cif.i_out_valid = 1'b1;
        cif.i_out_data  = v;
        @(posedge clk); #1;
        cif.i_out_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !done; i++) begin @(posedge clk); #1; end
        check(tag, done, 1);
    endtask

    task automatic push_bytes();
        for (int i = 0; i < 2048; i++) byte_q.push_back(in_mem[i]);
    endtask

    task automatic stream(input bit toggle);
        for (int i = 0; i < 6000 && !(byte_q.size() == 0 && !cif.o_in_valid); i++) begin
            cif.i_in_ready = toggle ? ~cif.i_in_ready : 1'b1;
            @(posedge clk); #1;
        end
        check("load_complete", byte_q.size(), 0);
        cif.i_in_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_op_valid"}, cif.o_op_valid, 0);
        check({tag, "_op_mode"}, cif.o_op_mode, 0);
        check({tag, "_in_valid"}, cif.o_in_valid, 0);
        check({tag, "_in_data"}, cif.o_in_data, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_tmo"}, timeout, 0);
        check({tag, "_op_addr"}, op_addr, 0);
        check({tag, "_in_addr"}, in_addr, 0);
        check({tag, "_gold_addr"}, gold_addr, 0);
    endtask

    initial begin
        int exp_err;
        rst = 1'b1; start = 1'b0; wd_start = 1'b0;
        cif.i_op_ready = 1'b0; cif.i_in_ready = 1'b0;
        cif.i_out_valid = 1'b0; cif.i_out_data = '0;
        gold_mem[0] = 14'sd5;    gold_mem[1] = -14'sd3;
        gold_mem[2] = 14'sd8191; gold_mem[3] = -14'sd8192;
        bad_vals[0] = 14'sd5;    bad_vals[1] = -14'sd2;
        bad_vals[2] = 14'sd8191; bad_vals[3] = 14'sd0;
        for (int i = 0; i < 2048; i++) in_mem[i] = 8'($urandom);
        op_mem[0] = 4'd1; op_mem[1] = 4'd2;
        repeat (3) @(posedge clk); #1;
        check_zero("reset");
        rst = 1'b0;

        // watchdog: op_ready stuck low, timeout exactly 50 cycles after the start edge
        wd_start = 1'b1; @(posedge clk); #1; wd_start = 1'b0;
        repeat (49) @(posedge clk); #1;
        check("wd_early_tmo", wd_timeout, 0);
        check("wd_early_done", wd_done, 0);
        @(posedge clk); #1;
        check("wd_tmo", wd_timeout, 1);
        check("wd_done", wd_done, 1);
        check("wd_op_valid", wif.o_op_valid, 0);
        check("wd_in_valid", wif.o_in_valid, 0);

        // two non-load ops, op strobe two cycles after ready is sampled
        op_q.push_back(4'd1); op_q.push_back(4'd2);
        cif.i_op_ready = 1'b1;
        pulse_start();
        @(posedge clk); #1; check("gap_quiet", cif.o_op_valid, 0);
        @(posedge clk); #1; check("issue1_valid", cif.o_op_valid, 1);
        check("issue1_mode", cif.o_op_mode, 1);
        @(posedge clk); #1; check("issue1_pulse", cif.o_op_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1; check("issue2_valid", cif.o_op_valid, 1);
        check("issue2_mode", cif.o_op_mode, 2);
        for (int i = 0; i < 4; i++) drive_out(gold_mem[i]);
        @(posedge clk); #1;
        check("match_done", done, 1);
        check("match_err", err_cnt, 0);
        check("match_gold_idx", gold_addr, 4);
        check("ops_consumed", op_q.size(), 0);
        drive_out(14'sd7);
        check("overflow", overflow, 1);
        check("overflow_err", err_cnt, 0);

        // restart from DONE with two mismatching samples
        exp_err = 0;
        for (int i = 0; i < 4; i++) if (bad_vals[i] != gold_mem[i]) exp_err++;
        op_q.push_back(4'd1); op_q.push_back(4'd2);
        pulse_start();
        check("restart_err", err_cnt, 0);
        check("restart_ovf", overflow, 0);
        check("restart_done", done, 0);
        for (int i = 0; i < 4; i++) drive_out(bad_vals[i]);
        wait_done("mismatch_done");
        check("mismatch_err", err_cnt, exp_err);
        check("mismatch_ops", op_q.size(), 0);

        // load op with in_ready toggling, then one plain op
        op_mem[0] = 4'd0; op_mem[1] = 4'd1;
        op_q.push_back(4'd0); op_q.push_back(4'd1);
        push_bytes();
        pulse_start();
        stream(1'b1);
        for (int i = 0; i < 4; i++) drive_out(gold_mem[i]);
        wait_done("load_done");
        check("load_err", err_cnt, 0);
        check("load_ops", op_q.size(), 0);

        // reset in the middle of a load, then a clean restart from byte 0
        op_q.push_back(4'd0); op_q.push_back(4'd1);
        push_bytes();
        n_xfer = 0;
        cif.i_in_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 1000 && n_xfer < 100; i++) begin @(posedge clk); #1; end
        cif.i_in_ready = 1'b0;
        #1 check("abort_in_idx", in_addr, 100);
        rst = 1'b1;
        #1 check_zero("abort");
        byte_q.delete(); op_q.delete();
        @(posedge clk); #1; rst = 1'b0;
        op_q.push_back(4'd0); op_q.push_back(4'd1);
        push_bytes();
        pulse_start();
        stream(1'b0);
        for (int i = 0; i < 4; i++) drive_out(gold_mem[i]);
        wait_done("rerun_done");
        check("rerun_err", err_cnt, 0);
        check("rerun_tmo", timeout, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
